// File: rtl/mreq_pkg.sv
// Shared types for the memory-request to Wishbone master: word sizes, FSM states
// and the size-to-byte-count helper.
package mreq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    WSIZE_1  = 2'd0,
    WSIZE_2  = 2'd1,
    WSIZE_4  = 2'd2,
    WSIZE_4X = 2'd3
  } wsize_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_BUS   = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  // Encoding 3 behaves exactly like a 4-byte word.
  function automatic logic [2:0] size_bytes(input wsize_e wsize);
    case (wsize)
      WSIZE_1: size_bytes = 3'd1;
      WSIZE_2: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mreq_wb_master_if.sv
// Request, write-data, read-data and Wishbone signal bundle of mreq_wb_master.
interface mreq_wb_master_if #(
  parameter int unsigned WB_ABITS = 30
);

  logic                i_mreq_valid;
  logic                i_mreq_ready;
  logic                i_mreq_wr;
  logic                i_mreq_aincr;
  logic [1:0]          i_mreq_wsize;
  logic [7:0]          i_mreq_wcount;
  logic [31:0]         i_mreq_addr;

  logic [31:0]         i_wdata;
  logic                i_wdata_valid;
  logic                o_wdata_ready;

  logic [31:0]         o_rdata;
  logic                o_rdata_valid;
  logic                i_rdata_ready;

  logic                o_wb_cyc;
  logic                o_wb_stb;
  logic                o_wb_we;
  logic [WB_ABITS-1:0] o_wb_adr;
  logic [31:0]         o_wb_dat;
  logic [3:0]          o_wb_sel;
  logic                i_wb_ack;
  logic [31:0]         i_wb_dat;

  logic                o_busy;

  modport master (
    input  i_mreq_valid, i_mreq_wr, i_mreq_aincr, i_mreq_wsize, i_mreq_wcount, i_mreq_addr,
    input  i_wdata, i_wdata_valid, i_rdata_ready, i_wb_ack, i_wb_dat,
    output i_mreq_ready, o_wdata_ready, o_rdata, o_rdata_valid,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel, o_busy
  );

  modport slave (
    output i_mreq_valid, i_mreq_wr, i_mreq_aincr, i_mreq_wsize, i_mreq_wcount, i_mreq_addr,
    output i_wdata, i_wdata_valid, i_rdata_ready, i_wb_ack, i_wb_dat,
    input  i_mreq_ready, o_wdata_ready, o_rdata, o_rdata_valid,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel, o_busy
  );

endinterface

// File: rtl/mreq_lane_mux.sv
// Byte-lane select, write-data shift and read-data extract for 1/2/4-byte words;
// low address bits are aligned down to the word size.
module mreq_lane_mux
  import mreq_pkg::*;
(
  input  wsize_e      wsize,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_dat,
  output logic [3:0]  sel_c,
  output logic [31:0] wdata_lane_c,
  output logic [31:0] rdata_lane_c
);

  always_comb begin
    sel_c        = 4'b1111;
    wdata_lane_c = wdata;
    rdata_lane_c = bus_dat;
    case (wsize)
      WSIZE_1: begin
        sel_c        = 4'b0001 << addr_lo;
        wdata_lane_c = {24'd0, wdata[7:0]} << {addr_lo, 3'b000};
        rdata_lane_c = {24'd0, 8'(bus_dat >> {addr_lo, 3'b000})};
      end
      WSIZE_2: begin
        sel_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane_c = addr_lo[1] ? {wdata[15:0], 16'd0} : {16'd0, wdata[15:0]};
        rdata_lane_c = {16'd0, addr_lo[1] ? bus_dat[31:16] : bus_dat[15:0]};
      end
      default: begin
        sel_c        = 4'b1111;
        wdata_lane_c = wdata;
        rdata_lane_c = bus_dat;
      end
    endcase
  end

endmodule

// File: rtl/mreq_wb_master.sv
// Converts counted, optionally address-incrementing memory requests into
// one Wishbone classic cycle per word, with write-data and read-data handshakes.
module mreq_wb_master
  import mreq_pkg::*;
#(
  parameter int unsigned WB_ABITS = 30
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mreq_wb_master_if.master   bus
);

  state_e      state_q, state_nxt;
  logic        wr_q, wr_nxt;
  logic        aincr_q, aincr_nxt;
  wsize_e      wsize_q, wsize_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [7:0]  rem_q, rem_nxt;
  logic [31:0] wdat_q, wdat_nxt;
  logic [31:0] rdat_q, rdat_nxt;

  logic        ready_q, ready_d;
  logic        wdata_ready_q, wdata_ready_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        word_done;
  logic [3:0]  lane_sel_c;
  logic [31:0] lane_wdata_c;
  logic [31:0] lane_rdata_c;

  assign accept    = (state_q == ST_IDLE) && ready_q && bus.i_mreq_valid;
  assign word_done = ((state_q == ST_BUS) && bus.i_wb_ack && wr_q) ||
                     ((state_q == ST_RDATA) && bus.i_rdata_ready);

  // Lane logic sees the address of the word about to be (or being) transferred.
  mreq_lane_mux u_lane_mux (
    .wsize        (wsize_nxt),
    .addr_lo      (addr_nxt[1:0]),
    .wdata        (bus.i_wdata),
    .bus_dat      (bus.i_wb_dat),
    .sel_c        (lane_sel_c),
    .wdata_lane_c (lane_wdata_c),
    .rdata_lane_c (lane_rdata_c)
  );

  // Request attributes, word counter and address stepping.
  always_comb begin
    wr_nxt    = wr_q;
    aincr_nxt = aincr_q;
    wsize_nxt = wsize_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    if (accept) begin
      wr_nxt    = bus.i_mreq_wr;
      aincr_nxt = bus.i_mreq_aincr;
      wsize_nxt = wsize_e'(bus.i_mreq_wsize);
      addr_nxt  = bus.i_mreq_addr;
      rem_nxt   = bus.i_mreq_wcount;
    end else if (word_done && (rem_q != 8'd0)) begin
      rem_nxt = rem_q - 8'd1;
      if (aincr_q) begin
        addr_nxt = addr_q + 32'(size_bytes(wsize_q));
      end
    end
  end

  // Next state and data capture.
  always_comb begin
    state_nxt = state_q;
    wdat_nxt  = wdat_q;
    rdat_nxt  = rdat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = bus.i_mreq_wr ? ST_WDATA : ST_BUS;
        end
      end
      ST_WDATA: begin
        if (bus.i_wdata_valid) begin
          wdat_nxt  = lane_wdata_c;
          state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus.i_wb_ack && !wr_q) begin
          rdat_nxt  = lane_rdata_c;
          state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (word_done) begin
      state_nxt = (rem_q == 8'd0) ? ST_IDLE : (wr_q ? ST_WDATA : ST_BUS);
    end
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    ready_d       = (state_nxt == ST_IDLE);
    wdata_ready_d = (state_nxt == ST_WDATA);
    rdata_valid_d = (state_nxt == ST_RDATA);
    cyc_d         = (state_nxt == ST_BUS);
    we_d          = cyc_d && wr_nxt;
    sel_d         = cyc_d ? lane_sel_c : 4'b0000;
    busy_d        = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      aincr_q       <= 1'b0;
      wsize_q       <= WSIZE_1;
      addr_q        <= 32'd0;
      rem_q         <= 8'd0;
      wdat_q        <= 32'd0;
      rdat_q        <= 32'd0;
      ready_q       <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= 4'b0000;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      wr_q          <= wr_nxt;
      aincr_q       <= aincr_nxt;
      wsize_q       <= wsize_nxt;
      addr_q        <= addr_nxt;
      rem_q         <= rem_nxt;
      wdat_q        <= wdat_nxt;
      rdat_q        <= rdat_nxt;
      ready_q       <= ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.i_mreq_ready  = ready_q;
  assign bus.o_wdata_ready = wdata_ready_q;
  assign bus.o_rdata       = rdat_q;
  assign bus.o_rdata_valid = rdata_valid_q;
  assign bus.o_wb_cyc      = cyc_q;
  assign bus.o_wb_stb      = cyc_q;
  assign bus.o_wb_we       = we_q;
  assign bus.o_wb_adr      = addr_q[WB_ABITS+1:2];
  assign bus.o_wb_dat      = wdat_q;
  assign bus.o_wb_sel      = sel_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_mreq_wb_master.sv
// Scoreboard bench for mreq_wb_master: a request model queues expected bus
// cycles and read words, and a cycle-stepped slave pops and compares them.
module tb_mreq_wb_master;

  localparam int unsigned WB_ABITS = 30;

  typedef struct {
    logic                we;
    logic [WB_ABITS-1:0] adr;
    logic [3:0]          sel;
    logic [31:0]         dat;
    logic [31:0]         rsp;
  } bus_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mreq_wb_master_if #(.WB_ABITS(WB_ABITS)) bus ();

  mreq_wb_master #(.WB_ABITS(WB_ABITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  bus_t        bus_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] rd_q[$];
  int tests = 0;
  int fails = 0;
  int acks  = 0;

  task automatic drive_idle();
    bus.i_mreq_valid  = 1'b0;
    bus.i_mreq_wr     = 1'b0;
    bus.i_mreq_aincr  = 1'b0;
    bus.i_mreq_wsize  = 2'd0;
    bus.i_mreq_wcount = 8'd0;
    bus.i_mreq_addr   = 32'd0;
    bus.i_wdata       = 32'd0;
    bus.i_wdata_valid = 1'b0;
    bus.i_rdata_ready = 1'b0;
    bus.i_wb_ack      = 1'b0;
    bus.i_wb_dat      = 32'd0;
  endtask

  // Reference model: byte count n, lanes derived from the n-aligned address.
  task automatic push_req(input logic wr, input logic aincr, input logic [1:0] ws,
                          input logic [7:0] wc, input logic [31:0] addr,
                          input logic [31:0] fixed, input bit use_fixed);
    int          n;
    int          lane;
    logic [31:0] a, base, mask, word;
    bus_t        t;
    n = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : 4;
    a = addr;
    for (int i = 0; i <= int'(wc); i++) begin
      base  = a & ~32'(n - 1);
      lane  = int'(base[1:0]);
      mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      word  = use_fixed ? fixed : $urandom;
      t.we  = wr;
      t.adr = a[31:2];
      t.sel = 4'(((1 << n) - 1) << lane);
      if (wr) begin
        wd_q.push_back(word);
        t.dat = (word & mask) << (8 * lane);
        t.rsp = 32'd0;
      end else begin
        t.dat = 32'd0;
        t.rsp = word;
        rd_q.push_back((word >> (8 * lane)) & mask);
      end
      bus_q.push_back(t);
      if (aincr) a = a + 32'(n);
    end
  endtask

  task automatic issue(input logic wr, input logic aincr, input logic [1:0] ws,
                       input logic [7:0] wc, input logic [31:0] addr,
                       input logic [31:0] fixed, input bit use_fixed);
    push_req(wr, aincr, ws, wc, addr, fixed, use_fixed);
    @(negedge clk);
    tests++;
    if (bus.i_mreq_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: got %b expected 1", bus.i_mreq_ready);
    end
    bus.i_mreq_wr     = wr;
    bus.i_mreq_aincr  = aincr;
    bus.i_mreq_wsize  = ws;
    bus.i_mreq_wcount = wc;
    bus.i_mreq_addr   = addr;
    bus.i_mreq_valid  = 1'b1;
  endtask

  // Slave and data-side responder, stepped on the falling edge until idle.
  task automatic service(input int wait_n, input int rdy_hold);
    int          wcnt, hold, cycles;
    bit          acked_prev, done;
    logic [31:0] held, exp_r;
    bus_t        t;
    wcnt = 0; hold = 0; cycles = 0; acked_prev = 0; done = 0; held = 32'd0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      bus.i_mreq_valid  = 1'b0;
      bus.i_wb_ack      = 1'b0;
      bus.i_wdata_valid = 1'b0;
      bus.i_rdata_ready = 1'b0;
      if (acked_prev) begin
        tests++;
        if (bus.o_wb_cyc !== 1'b0) begin
          fails++;
          $display("FAIL cyc_gap: got cyc=%b expected 0", bus.o_wb_cyc);
        end
      end
      acked_prev = 0;
      if (bus.o_busy !== 1'b1) begin
        done = 1;
      end else if (cycles > 4000) begin
        fails++;
        $display("FAIL timeout: got busy after %0d cycles expected idle", cycles);
        done = 1;
      end else begin
        if (bus.o_wdata_ready === 1'b1) begin
          if (wd_q.size() == 0) begin
            fails++;
            $display("FAIL wdata_extra: got wdata_ready=1 expected 0");
          end else begin
            bus.i_wdata       = wd_q.pop_front();
            bus.i_wdata_valid = 1'b1;
          end
        end
        if (bus.o_wb_cyc === 1'b1) begin
          if (wcnt >= wait_n) begin
            tests++;
            if (bus_q.size() == 0) begin
              fails++;
              $display("FAIL bus_extra: got cyc adr=%h expected none", bus.o_wb_adr);
            end else begin
              t = bus_q.pop_front();
              if (bus.o_wb_stb !== 1'b1 || bus.o_wb_we !== t.we || bus.o_wb_adr !== t.adr ||
                  bus.o_wb_sel !== t.sel || (t.we && bus.o_wb_dat !== t.dat)) begin
                fails++;
                $display("FAIL bus_cycle: got stb=%b we=%b adr=%h sel=%b dat=%h expected stb=1 we=%b adr=%h sel=%b dat=%h",
                         bus.o_wb_stb, bus.o_wb_we, bus.o_wb_adr, bus.o_wb_sel, bus.o_wb_dat,
                         t.we, t.adr, t.sel, t.dat);
              end
              bus.i_wb_dat = t.rsp;
            end
            bus.i_wb_ack = 1'b1;
            acks++;
            acked_prev = 1;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
        if (bus.o_rdata_valid === 1'b1) begin
          if (hold == 0) held = bus.o_rdata;
          if (hold < rdy_hold) begin
            tests++;
            if (bus.o_wb_stb !== 1'b0 || bus.o_rdata !== held) begin
              fails++;
              $display("FAIL rdata_hold: got stb=%b rdata=%h expected stb=0 rdata=%h",
                       bus.o_wb_stb, bus.o_rdata, held);
            end
            hold++;
          end else begin
            tests++;
            exp_r = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_DEAD;
            if (bus.o_rdata !== exp_r) begin
              fails++;
              $display("FAIL rdata: got %h expected %h", bus.o_rdata, exp_r);
            end
            bus.i_rdata_ready = 1'b1;
            hold = 0;
          end
        end
      end
    end
    tests++;
    if (bus_q.size() != 0 || rd_q.size() != 0 || wd_q.size() != 0 || bus.o_wb_cyc !== 1'b0) begin
      fails++;
      $display("FAIL end_of_request: got pending bus=%0d rd=%0d wd=%0d cyc=%b expected 0 0 0 0",
               bus_q.size(), rd_q.size(), wd_q.size(), bus.o_wb_cyc);
    end
    bus_q.delete();
    rd_q.delete();
    wd_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.o_wb_we !== 1'b0 ||
        bus.o_wdata_ready !== 1'b0 || bus.o_rdata_valid !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.i_mreq_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_ctrl: got cyc=%b stb=%b we=%b wrdy=%b rvld=%b busy=%b rdy=%b expected all 0",
               tag, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wdata_ready,
               bus.o_rdata_valid, bus.o_busy, bus.i_mreq_ready);
    end
    tests++;
    if (bus.o_wb_adr !== '0 || bus.o_wb_dat !== 32'd0 || bus.o_wb_sel !== 4'd0 ||
        bus.o_rdata !== 32'd0) begin
      fails++;
      $display("FAIL %s_data: got adr=%h dat=%h sel=%b rdata=%h expected all 0",
               tag, bus.o_wb_adr, bus.o_wb_dat, bus.o_wb_sel, bus.o_rdata);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.i_mreq_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", bus.i_mreq_ready, bus.o_busy);
    end
  endtask

  task automatic test_read_burst();
    issue(1'b0, 1'b1, 2'd2, 8'd3, 32'h0000_0100, 32'd0, 1'b0);
    service(2, 0);
  endtask

  task automatic test_write_byte();
    issue(1'b1, 1'b0, 2'd0, 8'd0, 32'h0000_0203, 32'h0000_00AB, 1'b1);
    service(0, 0);
    @(negedge clk);
    tests++;
    if (bus.i_mreq_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL write_byte_idle: got ready=%b busy=%b expected 1 0", bus.i_mreq_ready, bus.o_busy);
    end
  endtask

  task automatic test_read_half_noinc();
    issue(1'b0, 1'b0, 2'd1, 8'd1, 32'h0000_0002, 32'hBEEF_1234, 1'b1);
    service(1, 0);
  endtask

  task automatic test_rdata_backpressure();
    issue(1'b0, 1'b1, 2'd0, 8'd1, 32'h0000_0011, 32'd0, 1'b0);
    service(0, 10);
  endtask

  task automatic test_reset_midbus();
    int guard;
    issue(1'b0, 1'b0, 2'd2, 8'd0, 32'h0000_0040, 32'd0, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      bus.i_mreq_valid = 1'b0;
      guard++;
    end while (bus.o_wb_cyc !== 1'b1 && guard < 10);
    tests++;
    if (bus.o_wb_cyc !== 1'b1) begin
      fails++;
      $display("FAIL midbus_reach: got cyc=%b expected 1", bus.o_wb_cyc);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("midbus_reset");
    bus_q.delete();
    rd_q.delete();
    wd_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.i_mreq_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL midbus_release: got ready=%b busy=%b expected 1 0", bus.i_mreq_ready, bus.o_busy);
    end
    issue(1'b0, 1'b1, 2'd2, 8'd1, 32'h0000_0080, 32'd0, 1'b0);
    service(1, 0);
  endtask

  task automatic test_wrap();
    issue(1'b1, 1'b1, 2'd2, 8'd1, 32'hFFFF_FFFC, 32'd0, 1'b0);
    service(0, 0);
  endtask

  task automatic test_long_write();
    acks = 0;
    issue(1'b1, 1'b1, 2'($urandom_range(3)), 8'd255, $urandom, 32'd0, 1'b0);
    service(0, 0);
    tests++;
    if (acks != 256) begin
      fails++;
      $display("FAIL long_acks: got %0d expected 256", acks);
    end
  endtask

  task automatic test_ignore();
    @(negedge clk);
    bus.i_wb_ack      = 1'b1;
    bus.i_wdata_valid = 1'b1;
    bus.i_rdata_ready = 1'b1;
    @(negedge clk);
    bus.i_wb_ack      = 1'b0;
    bus.i_wdata_valid = 1'b0;
    bus.i_rdata_ready = 1'b0;
    tests++;
    if (bus.o_busy !== 1'b0 || bus.o_wb_cyc !== 1'b0 || bus.o_wdata_ready !== 1'b0 ||
        bus.o_rdata_valid !== 1'b0 || bus.i_mreq_ready !== 1'b1) begin
      fails++;
      $display("FAIL ignore_idle: got busy=%b cyc=%b wrdy=%b rvld=%b rdy=%b expected 0 0 0 0 1",
               bus.o_busy, bus.o_wb_cyc, bus.o_wdata_ready, bus.o_rdata_valid, bus.i_mreq_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_byte();
    test_read_half_noinc();
    test_rdata_backpressure();
    test_reset_midbus();
    test_wrap();
    test_long_write();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mreq_wb_master.md
MREQ_WB_MASTER -- requirements
Module: mreq_wb_master

Interface
REQ-001 Parameter WB_ABITS, default 30, meaning Wishbone word-address width; o_wb_adr carries byte address bits [WB_ABITS+1:2].
REQ-002 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_mreq_valid  input  1  request present; i_mreq_ready  output  1  request accepted on the cycle both are high.
REQ-005 i_mreq_wr  input  1  1=write, 0=read; i_mreq_aincr  input  1  address increment enable.
REQ-006 i_mreq_wsize  input  2  word size: 0=1 byte, 1=2 bytes, 2=4 bytes, 3=treated as 4 bytes.
REQ-007 i_mreq_wcount  input  8  word count minus one (0 means 1 word, 255 means 256 words); i_mreq_addr  input  32  byte address.
REQ-008 i_wdata  input  32  write word, LSB-aligned; i_wdata_valid  input  1; o_wdata_ready  output  1.
REQ-009 o_rdata  output  32  read word, LSB-aligned, zero-extended; o_rdata_valid  output  1; i_rdata_ready  input  1.
REQ-010 Wishbone classic master: o_wb_cyc, o_wb_stb, o_wb_we (1 each), o_wb_adr (WB_ABITS), o_wb_dat (32), o_wb_sel (4) outputs; i_wb_ack (1) and i_wb_dat (32) inputs.
REQ-011 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, WDATA, BUS, RDATA.
REQ-013 i_mreq_ready SHALL be high only in IDLE and SHALL depend on state alone, never combinationally on i_mreq_valid.
REQ-014 On accept, latch wr, aincr, wsize, addr; load the remaining counter with wcount; go to WDATA if wr, else BUS.
REQ-015 WDATA: o_wdata_ready=1; on i_wdata_valid, latch the word lane-shifted and go to BUS on the next cycle.
REQ-016 BUS: o_wb_cyc=o_wb_stb=1 and o_wb_we=latched wr, with adr, sel and dat held stable until the cycle in which i_wb_ack=1.
REQ-017 Byte lanes: low address bits are aligned down to the word size; size 1 gives sel=0001<<addr[1:0] and data<<8*addr[1:0]; size 2 gives sel=0011<<(2*addr[1]); size 4 gives sel=1111.
REQ-018 Read ack: capture i_wb_dat lane-extracted into o_rdata, drop cyc/stb, and go to RDATA.
REQ-019 RDATA: o_rdata_valid=1 with o_rdata stable until i_rdata_ready; no bus cycle is issued while the read word is pending.
REQ-020 End of word (write ack, or read handoff): if remaining==0 go to IDLE, else decrement remaining and add the size in bytes (1/2/4) to addr if aincr=1, then go to WDATA (write) or BUS (read).
REQ-021 Address arithmetic is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000 without error.
REQ-022 o_wb_cyc SHALL drop for at least one cycle between words; no back-to-back stb.
REQ-023 i_wb_ack outside BUS, i_wdata_valid outside WDATA, and i_mreq_valid outside IDLE SHALL be ignored.
REQ-024 Zero-wait-state slave (ack in the first BUS cycle) completes a word in BUS for 1 cycle.

Reset
REQ-025 While i_rst is high, and immediately on its assertion (asynchronously): state=IDLE, and o_wb_cyc, o_wb_stb, o_wb_we, o_wdata_ready, o_rdata_valid and o_busy are 0.
REQ-026 Also while i_rst is high: o_wb_adr, o_wb_dat, o_wb_sel, o_rdata and internal counters are 0, and i_mreq_ready is 0.
REQ-027 Reset mid-transfer abandons the request; the first cycle after deassertion is IDLE with i_mreq_ready=1.

Structure
REQ-028 Shared package mreq_pkg holds the wsize encodings, the size-to-byte-count function and the state enumeration.
REQ-029 Byte-lane select, shift and extract logic is one combinational sub-module, mreq_lane_mux.

Verification
REQ-030 Read, addr=0x100, wsize=2, wcount=3, aincr=1, ack after 2 waits -> adr 0x40,0x41,0x42,0x43 with sel=1111 and 4 rdata words in order.
REQ-031 Write, addr=0x203, wsize=0, wcount=0, wdata=0xAB -> sel=1000, dat=0xAB000000, we=1, then IDLE.
REQ-032 Read, wsize=1, addr=0x2, aincr=0, wcount=1, i_wb_dat=0xBEEF1234 -> two reads of adr 0x0 with sel=1100, rdata=0x0000BEEF twice.
REQ-033 Read with i_rdata_ready held low 10 cycles -> no stb during those cycles and o_rdata stable.
REQ-034 Assert i_rst while BUS is waiting for ack -> cyc/stb are 0 in the same cycle; after release, a new request completes normally.
REQ-035 Write, addr=0xFFFFFFFC, wsize=2, wcount=1, aincr=1 -> second word at adr 0x0; wcount=255 -> exactly 256 acks.
